// File: rtl/sort_mem_if.sv
// rtl/sort_mem_if.sv - read/write channel bundle between the sort datapath and sort_mem
interface sort_mem_if #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
);
    logic                 ar_valid;
    logic                 ar_ready;
    logic [ADDR_WDTH-1:0] ar_address;
    logic                 r_valid;
    logic                 r_ready;
    logic [DATA_WDTH-1:0] r_data;
    logic [RESP_WDTH-1:0] r_resp;
    logic                 aw_valid;
    logic                 aw_ready;
    logic [ADDR_WDTH-1:0] aw_address;
    logic                 w_valid;
    logic                 w_ready;
    logic [DATA_WDTH-1:0] w_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [RESP_WDTH-1:0] b_resp;

    // datapath side
    modport master (
        output ar_valid, ar_address, r_ready,
        output aw_valid, aw_address, w_valid, w_data, b_ready,
        input  ar_ready, r_valid, r_data, r_resp,
        input  aw_ready, w_ready, b_valid, b_resp
    );

    // memory side
    modport slave (
        input  ar_valid, ar_address, r_ready,
        input  aw_valid, aw_address, w_valid, w_data, b_ready,
        output ar_ready, r_valid, r_data, r_resp,
        output aw_ready, w_ready, b_valid, b_resp
    );
endinterface

// File: rtl/sort_mem.sv
// rtl/sort_mem.sv - word memory with independent read/write handshake FSMs; SORT_MEM_CLR_EN clears storage on rst
module sort_mem #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1,
    parameter int MEM_DEPTH = 16
) (
    input logic     clk,
    input logic     rst,
    sort_mem_if.slave bus
);
    localparam int                   NWORDS    = 1 << ADDR_WDTH;
    localparam logic [ADDR_WDTH:0]   DEPTH     = (ADDR_WDTH+1)'(MEM_DEPTH);
    localparam logic [RESP_WDTH-1:0] RESP_OKAY = '0;
    localparam logic [RESP_WDTH-1:0] RESP_ERR  = RESP_WDTH'(1);

    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;

    logic [DATA_WDTH-1:0] mem [NWORDS];

    rd_state_t            rd_state_q;
    logic                 ar_ready_q, r_valid_q;
    logic [DATA_WDTH-1:0] r_data_q;
    logic [RESP_WDTH-1:0] r_resp_q;

    wr_state_t            wr_state_q;
    logic                 aw_got_q, w_got_q;
    logic                 aw_ready_q, w_ready_q, b_valid_q;
    logic [RESP_WDTH-1:0] b_resp_q;
    logic [ADDR_WDTH-1:0] aw_addr_q;
    logic [DATA_WDTH-1:0] w_data_q;

    logic                 rd_in_range;
    logic                 aw_hs, w_hs, aw_got_d, w_got_d;
    logic                 wr_commit, wr_in_range;
    logic [ADDR_WDTH-1:0] wr_addr;
    logic [DATA_WDTH-1:0] wr_data;

    // Handshake decode; a commit uses either the captured beat or the one landing now
    always_comb begin
        rd_in_range = {1'b0, bus.ar_address} < DEPTH;
        aw_hs       = bus.aw_valid && aw_ready_q;
        w_hs        = bus.w_valid && w_ready_q;
        aw_got_d    = aw_got_q || aw_hs;
        w_got_d     = w_got_q || w_hs;
        wr_addr     = aw_got_q ? aw_addr_q : bus.aw_address;
        wr_data     = w_got_q ? w_data_q : bus.w_data;
        wr_in_range = {1'b0, wr_addr} < DEPTH;
        wr_commit   = !rst && (wr_state_q == WR_IDLE) && aw_got_d && w_got_d;
    end

    // Read FSM: sample the word on AR, hold it until R is consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    ar_ready_q <= 1'b1;
                    if (bus.ar_valid && ar_ready_q) begin
                        r_data_q   <= rd_in_range ? mem[bus.ar_address] : '0;
                        r_resp_q   <= rd_in_range ? RESP_OKAY : RESP_ERR;
                        r_valid_q  <= 1'b1;
                        ar_ready_q <= 1'b0;
                        rd_state_q <= RD_RESP;
                    end
                end
                default: begin
                    if (bus.r_ready) begin
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                        rd_state_q <= RD_IDLE;
                    end
                end
            endcase
        end
    end

    // Write FSM: collect AW and W in any order, commit on the second, then answer on B
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= WR_IDLE;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    if (aw_hs) aw_addr_q <= bus.aw_address;
                    if (w_hs)  w_data_q  <= bus.w_data;
                    if (wr_commit) begin
                        aw_got_q   <= 1'b0;
                        w_got_q    <= 1'b0;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                        b_valid_q  <= 1'b1;
                        b_resp_q   <= wr_in_range ? RESP_OKAY : RESP_ERR;
                        wr_state_q <= WR_RESP;
                    end else begin
                        aw_got_q   <= aw_got_d;
                        w_got_q    <= w_got_d;
                        aw_ready_q <= !aw_got_d;
                        w_ready_q  <= !w_got_d;
                    end
                end
                default: begin
                    if (bus.b_ready) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        wr_state_q <= WR_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef SORT_MEM_CLR_EN
    // Storage: cleared while rst is high, otherwise written on an in-range commit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NWORDS; i++) mem[i] <= '0;
        end else if (wr_commit && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
    end
`else
    // Storage: contents survive reset; written only on an in-range commit
    always_ff @(posedge clk) begin
        if (wr_commit && wr_in_range) mem[wr_addr] <= wr_data;
    end
`endif

    assign bus.ar_ready = ar_ready_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.r_data   = r_data_q;
    assign bus.r_resp   = r_resp_q;
    assign bus.aw_ready = aw_ready_q;
    assign bus.w_ready  = w_ready_q;
    assign bus.b_valid  = b_valid_q;
    assign bus.b_resp   = b_resp_q;
endmodule

// File: tb/tb_sort_mem.sv
// tb/tb_sort_mem.sv - directed self-checking bench for sort_mem (MEM_DEPTH=10)
module tb_sort_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sort_mem_if #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) bus ();

    sort_mem #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .MEM_DEPTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_rd_ready();
        for (int i = 0; i < 20 && bus.ar_ready !== 1'b1; i++) step();
        chk("ar_ready_wait", 32'(bus.ar_ready), 32'd1);
    endtask

    task automatic wait_wr_ready();
        for (int i = 0; i < 20 && (bus.aw_ready !== 1'b1 || bus.w_ready !== 1'b1); i++) step();
        chk("wr_ready_wait", {30'd0, bus.aw_ready, bus.w_ready}, 32'd3);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic e);
        wait_wr_ready();
        bus.aw_valid = 1'b1; bus.aw_address = a;
        bus.w_valid  = 1'b1; bus.w_data     = d;
        bus.b_ready  = 1'b1;
        step();
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        chk("wr_b_valid", 32'(bus.b_valid), 32'd1);
        chk("wr_b_resp",  32'(bus.b_resp), 32'(e));
        step();
        chk("wr_b_done",  32'(bus.b_valid), 32'd0);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] d, input logic e);
        wait_rd_ready();
        bus.ar_valid = 1'b1; bus.ar_address = a; bus.r_ready = 1'b1;
        step();
        bus.ar_valid = 1'b0;
        chk("rd_r_valid", 32'(bus.r_valid), 32'd1);
        chk("rd_r_data",  bus.r_data, d);
        chk("rd_r_resp",  32'(bus.r_resp), 32'(e));
        step();
        chk("rd_r_done",  32'(bus.r_valid), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {bus.ar_ready, bus.r_valid, bus.r_resp, bus.aw_ready,
                  bus.w_ready, bus.b_valid, bus.b_resp, 25'd0}, 32'd0);
        chk({tag, "_r_data"}, bus.r_data, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_after_rst;
        bus.ar_valid = 1'b0; bus.ar_address = '0; bus.r_ready = 1'b1;
        bus.aw_valid = 1'b0; bus.aw_address = '0;
        bus.w_valid  = 1'b0; bus.w_data     = '0; bus.b_ready = 1'b1;

        // reset state
        step(); step();
        chk_all_zero("reset");
        rst = 1'b0;
        chk_all_zero("reset_release");
        step();
        chk("ready_after_rst", {29'd0, bus.ar_ready, bus.aw_ready, bus.w_ready}, 32'd7);

        // write then read, AW and W together
        do_write(4'd3, 32'hDEAD_BEEF, 1'b0);
        do_read(4'd3, 32'hDEAD_BEEF, 1'b0);

        // split channels: W first, AW four cycles later
        wait_wr_ready();
        bus.w_valid = 1'b1; bus.w_data = 32'h5;
        step();
        bus.w_valid = 1'b0;
        chk("split_aw_ready", 32'(bus.aw_ready), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            chk("split_w_ready", 32'(bus.w_ready), 32'd0);
            chk("split_b_valid", 32'(bus.b_valid), 32'd0);
            step();
        end
        chk("split_w_ready_c4", 32'(bus.w_ready), 32'd0);
        bus.aw_valid = 1'b1; bus.aw_address = 4'd7;
        step();
        bus.aw_valid = 1'b0;
        chk("split_b_valid_c5", 32'(bus.b_valid), 32'd1);
        chk("split_b_resp", 32'(bus.b_resp), 32'd0);
        step();
        do_read(4'd7, 32'h5, 1'b0);

        // collision: read and commit on the same edge at address 2
        do_write(4'd2, 32'hA, 1'b0);
        wait_rd_ready();
        wait_wr_ready();
        bus.ar_valid = 1'b1; bus.ar_address = 4'd2;
        bus.aw_valid = 1'b1; bus.aw_address = 4'd2;
        bus.w_valid  = 1'b1; bus.w_data     = 32'hB;
        step();
        bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        chk("coll_r_data", bus.r_data, 32'hA);
        chk("coll_b_valid", 32'(bus.b_valid), 32'd1);
        step();
        do_read(4'd2, 32'hB, 1'b0);

        // out of range (depth 10): no write, ERR on both paths, no aliasing
        do_write(4'd4, 32'h44, 1'b0);
        do_write(4'd12, 32'h1234, 1'b1);
        do_read(4'd12, 32'h0, 1'b1);
        do_read(4'd9, 32'h0, 1'b0);
        do_write(4'd10, 32'h99, 1'b1);
        do_read(4'd2, 32'hB, 1'b0);
        do_read(4'd3, 32'hDEAD_BEEF, 1'b0);
        do_read(4'd4, 32'h44, 1'b0);
        do_read(4'd7, 32'h5, 1'b0);

        // backpressure on R
        wait_rd_ready();
        bus.ar_valid = 1'b1; bus.ar_address = 4'd3; bus.r_ready = 1'b0;
        step();
        bus.ar_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_r_valid", 32'(bus.r_valid), 32'd1);
            chk("bp_r_data", bus.r_data, 32'hDEAD_BEEF);
            chk("bp_ar_ready", 32'(bus.ar_ready), 32'd0);
            step();
        end
        bus.r_ready = 1'b1;
        step();
        chk("bp_ar_ready_back", 32'(bus.ar_ready), 32'd1);
        chk("bp_r_valid_low", 32'(bus.r_valid), 32'd0);

        // reset pulse
        do_write(4'd1, 32'h77, 1'b0);
        do_read(4'd1, 32'h77, 1'b0);
        rst = 1'b1;
        step();
        chk_all_zero("rst_pulse");
        rst = 1'b0;
        step();
`ifdef SORT_MEM_CLR_EN
        exp_after_rst = 32'h0;
`else
        exp_after_rst = 32'h77;
`endif
        do_read(4'd1, exp_after_rst, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
